mem_ctrl: RTL and testbench

Memory controller that answers the fetcher's instruction requests and the load/store buffer's data requests on the single byte-wide RAM port. It latches one-cycle request pulses from both clients and arbitrates between them. Each request is split into sequential byte accesses, and read data is reassembled little-endian. The controller returns results with a one-cycle ready pulse. On a misbranch it aborts speculative traffic (fetches and loads) and lets stores complete.

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Client request/response and byte-wide RAM signals of the memory controller.
interface mem_ctrl_if;
  logic        rdy;
  logic        has_misbranch;
  logic        if_ask;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ready;
  logic        ls_ask;
  logic        ls_wr;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ready;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  rdy, has_misbranch, if_ask, if_addr, ls_ask, ls_wr, ls_len, ls_addr, ls_wdata, mem_din,
    output if_data, if_ready, ls_rdata, ls_ready, mem_dout, mem_a, mem_wr
  );
  modport master (
    output rdy, has_misbranch, if_ask, if_addr, ls_ask, ls_wr, ls_len, ls_addr, ls_wdata, mem_din,
    input  if_data, if_ready, ls_rdata, ls_ready, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller: latches fetch and load/store requests, serves
// load/store first, moves one byte per cycle and reassembles reads little-endian.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e      state_q, state_d;
  logic        if_pend_q, if_pend_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic        ls_pend_q, ls_pend_d;
  logic        ls_wr_q, ls_wr_d;
  logic [1:0]  ls_len_q, ls_len_d;
  logic [31:0] ls_addr_q, ls_addr_d;
  logic [31:0] ls_wdata_q, ls_wdata_d;
  logic        op_ls_q, op_ls_d;   // operation in flight belongs to the load/store client
  logic [2:0]  len_q, len_d;       // bytes in the current operation
  logic [2:0]  cnt_q, cnt_d;       // bytes already transferred
  logic [31:0] base_q, base_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] if_data_q, if_data_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        ls_ready_q, ls_ready_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_wr_q, mem_wr_d;

  logic flush, read_abort, if_hold, ls_hold;

  function automatic logic [2:0] bytes_of(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Request capture, misbranch squash, arbitration and byte sequencing.
  always_comb begin
    state_d    = state_q;
    if_pend_d  = if_pend_q;
    if_addr_d  = if_addr_q;
    ls_pend_d  = ls_pend_q;
    ls_wr_d    = ls_wr_q;
    ls_len_d   = ls_len_q;
    ls_addr_d  = ls_addr_q;
    ls_wdata_d = ls_wdata_q;
    op_ls_d    = op_ls_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    if_data_d  = if_data_q;
    if_ready_d = 1'b0;
    ls_rdata_d = ls_rdata_q;
    ls_ready_d = 1'b0;
    mem_dout_d = mem_dout_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = mem_wr_q;

    flush      = bus.has_misbranch;
    read_abort = flush && (state_q == READ);
    // a port already holding a request (pending or in flight) ignores new asks
    if_hold    = if_pend_q || (state_q == READ && !op_ls_q);
    ls_hold    = (ls_pend_q && !(flush && !ls_wr_q)) ||
                 (state_q != IDLE && op_ls_q && !read_abort);

    // speculative requests die on a misbranch; stores survive
    if (flush) begin
      if_pend_d = 1'b0;
      if (!ls_wr_q) ls_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ls_pend_d) begin
          ls_pend_d = 1'b0;
          op_ls_d   = 1'b1;
          base_d    = ls_addr_q;
          mem_a_d   = ls_addr_q;
          len_d     = bytes_of(ls_len_q);
          cnt_d     = '0;
          rbuf_d    = '0;
          if (ls_wr_q) begin
            state_d    = WRITE;
            wbuf_d     = ls_wdata_q;
            mem_dout_d = ls_wdata_q[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = READ;
          end
        end else if (if_pend_d) begin
          if_pend_d = 1'b0;
          op_ls_d   = 1'b0;
          base_d    = if_addr_q;
          mem_a_d   = if_addr_q;
          len_d     = 3'd4;
          cnt_d     = '0;
          rbuf_d    = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rbuf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == len_q) begin
            state_d = IDLE;
            if (op_ls_q) begin
              ls_rdata_d = rbuf_d;
              ls_ready_d = 1'b1;
            end else begin
              if_data_d  = rbuf_d;
              if_ready_d = 1'b1;
            end
          end else begin
            mem_a_d = base_q + {29'd0, cnt_d};
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_d == len_q) begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          ls_ready_d = 1'b1;
        end else begin
          mem_a_d    = base_q + {29'd0, cnt_d};
          mem_dout_d = wbuf_q[{cnt_d[1:0], 3'b000} +: 8];
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.if_ask && !flush && !if_hold) begin
      if_pend_d = 1'b1;
      if_addr_d = bus.if_addr;
    end
    if (bus.ls_ask && !(flush && !bus.ls_wr) && !ls_hold) begin
      ls_pend_d  = 1'b1;
      ls_wr_d    = bus.ls_wr;
      ls_len_d   = bus.ls_len;
      ls_addr_d  = bus.ls_addr;
      ls_wdata_d = bus.ls_wdata;
    end
  end

  // State registers; rdy low holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      if_pend_q  <= 1'b0;
      if_addr_q  <= '0;
      ls_pend_q  <= 1'b0;
      ls_wr_q    <= 1'b0;
      ls_len_q   <= '0;
      ls_addr_q  <= '0;
      ls_wdata_q <= '0;
      op_ls_q    <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      if_data_q  <= '0;
      if_ready_q <= 1'b0;
      ls_rdata_q <= '0;
      ls_ready_q <= 1'b0;
      mem_dout_q <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      if_pend_q  <= if_pend_d;
      if_addr_q  <= if_addr_d;
      ls_pend_q  <= ls_pend_d;
      ls_wr_q    <= ls_wr_d;
      ls_len_q   <= ls_len_d;
      ls_addr_q  <= ls_addr_d;
      ls_wdata_q <= ls_wdata_d;
      op_ls_q    <= op_ls_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      if_data_q  <= if_data_d;
      if_ready_q <= if_ready_d;
      ls_rdata_q <= ls_rdata_d;
      ls_ready_q <= ls_ready_d;
      mem_dout_q <= mem_dout_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.if_data  = if_data_q;
  assign bus.if_ready = if_ready_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.ls_ready = ls_ready_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wr   = mem_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl. Expected ready cycles come from ask edge + 1 +
// byte count, expected data from a shadow byte memory, expected RAM writes
// from a queue of (address, byte) pairs.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if m ();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(m));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  bit          chk_en = 1'b0;
  int          exp_if_cyc = -1;
  int          exp_ls_cyc = -1;
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_ls_data = '0;
  bit          exp_ls_load = 1'b0;
  logic [7:0]  img    [0:4095];
  logic [7:0]  ram    [0:4095];
  logic [7:0]  shadow [0:4095];
  logic [31:0] wq_a[$];
  logic [7:0]  wq_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: combinational lookup of the registered address, write on the edge
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 4096; i++) ram[i] <= img[i];
    else if (m.mem_wr) ram[m.mem_a[11:0]] <= m.mem_dout;
  end
  assign m.mem_din = ram[m.mem_a[11:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input int n);
    logic [31:0] r, x;
    r = '0;
    for (int i = 0; i < n; i++) begin
      x = a + 32'(i);
      r[8*i +: 8] = shadow[x[11:0]];
    end
    return r;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    logic [31:0] x;
    for (int i = 0; i < n; i++) begin
      x = a + 32'(i);
      shadow[x[11:0]] = d[8*i +: 8];
      wq_a.push_back(x);
      wq_d.push_back(d[8*i +: 8]);
    end
  endtask

  task automatic expect_ls(input int e, input bit wr, input logic [1:0] len,
                           input logic [31:0] a, input logic [31:0] d);
    exp_ls_cyc  = e + 1 + nbytes(len);
    exp_ls_load = !wr;
    if (wr) model_wr(a, d, nbytes(len));
    else    exp_ls_data = model_rd(a, nbytes(len));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic if_req(input logic [31:0] a);
    m.if_ask  = 1'b1;
    m.if_addr = a;
  endtask

  task automatic ls_req(input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    m.ls_ask   = 1'b1;
    m.ls_wr    = wr;
    m.ls_len   = len;
    m.ls_addr  = a;
    m.ls_wdata = d;
  endtask

  task automatic drop_asks();
    m.if_ask = 1'b0;
    m.ls_ask = 1'b0;
  endtask

  // Per-cycle compare against the transaction model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_ready", 32'(m.if_ready), 32'(cyc == exp_if_cyc));
      chk("ls_ready", 32'(m.ls_ready), 32'(cyc == exp_ls_cyc));
      if (cyc == exp_if_cyc) chk("if_data", m.if_data, exp_if_data);
      if (cyc == exp_ls_cyc && exp_ls_load) chk("ls_rdata", m.ls_rdata, exp_ls_data);
      if (m.mem_wr && m.rdy) begin
        if (wq_a.size() == 0) chk("unexpected mem_wr", 32'(m.mem_wr), 32'd0);
        else begin
          chk("write addr", m.mem_a, wq_a.pop_front());
          chk("write byte", 32'(m.mem_dout), 32'(wq_d.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected end long before", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int e;
    logic [31:0] wrap_a [4];
    wrap_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    m.rdy = 1'b1; m.has_misbranch = 1'b0;
    m.if_ask = 1'b0; m.if_addr = '0;
    m.ls_ask = 1'b0; m.ls_wr = 1'b0; m.ls_len = '0; m.ls_addr = '0; m.ls_wdata = '0;
    for (int i = 0; i < 4096; i++) img[i] = 8'(i * 37 + 5);
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h5A; img[12'hFFE] = 8'h11; img[12'hFFF] = 8'h22;
    for (int i = 0; i < 4096; i++) shadow[i] = img[i];

    idle(3);
    rst = 1'b0;
    chk("reset if_data",  m.if_data, 32'h0);
    chk("reset if_ready", 32'(m.if_ready), 32'h0);
    chk("reset ls_rdata", m.ls_rdata, 32'h0);
    chk("reset ls_ready", 32'(m.ls_ready), 32'h0);
    chk("reset mem_dout", 32'(m.mem_dout), 32'h0);
    chk("reset mem_a",    m.mem_a, 32'h0);
    chk("reset mem_wr",   32'(m.mem_wr), 32'h0);
    chk_en = 1'b1;

    // fetch word at 0
    if_req(32'h0); step(); drop_asks(); e = cyc;
    exp_if_cyc = e + 5; exp_if_data = model_rd(32'h0, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fetch mem_a", m.mem_a, 32'(i));
    end
    step();
    chk("fetch if_data literal", m.if_data, 32'h0000_0013);

    // store word, then load half from its upper half
    ls_req(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    idle(5);
    ls_req(1'b0, 2'd1, 32'h102, 32'h0); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b0, 2'd1, 32'h102, 32'h0);
    idle(3);
    chk("load half literal", m.ls_rdata, 32'h0000_DEAD);

    // simultaneous asks: load first, fetch after one idle cycle
    if_req(32'h10); ls_req(1'b0, 2'd0, 32'h4, 32'h0); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b0, 2'd0, 32'h4, 32'h0);
    exp_if_cyc = e + 7; exp_if_data = model_rd(32'h10, 4);
    idle(2);
    chk("arb load literal", m.ls_rdata, 32'h0000_005A);
    idle(5);

    // misbranch two cycles into a fetch
    if_req(32'h20); step(); drop_asks(); e = cyc;
    exp_if_cyc = -1;
    idle(2);
    m.has_misbranch = 1'b1; step(); m.has_misbranch = 1'b0;
    chk("abort holds mem_a", m.mem_a, 32'h21);
    idle(6);
    if_req(32'h40); step(); drop_asks(); e = cyc;
    exp_if_cyc = e + 5; exp_if_data = model_rd(32'h40, 4);
    idle(5);

    // misbranch one cycle into a store; the queued fetch is dropped
    if_req(32'h80); ls_req(1'b1, 2'd3, 32'h200, 32'hCAFE_F00D); step(); drop_asks(); e = cyc;
    exp_if_cyc = -1;
    expect_ls(e, 1'b1, 2'd3, 32'h200, 32'hCAFE_F00D);
    idle(1);
    m.has_misbranch = 1'b1; step(); m.has_misbranch = 1'b0;
    idle(10);
    ls_req(1'b0, 2'd2, 32'h200, 32'h0); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b0, 2'd2, 32'h200, 32'h0);
    idle(5);
    chk("store survived flush", m.ls_rdata, 32'hCAFE_F00D);

    // word load wrapping past the top of the address space
    ls_req(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap mem_a", m.mem_a, wrap_a[i]);
    end
    step();
    chk("wrap load literal", m.ls_rdata, 32'h0013_2211);

    // rdy low for three cycles mid-load; a fetch asked meanwhile is not taken
    ls_req(1'b0, 2'd2, 32'h300, 32'h0); step(); drop_asks(); e = cyc;
    expect_ls(e, 1'b0, 2'd2, 32'h300, 32'h0);
    exp_ls_cyc = exp_ls_cyc + 3;
    exp_if_cyc = -1;
    idle(2);
    m.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) if_req(32'h44);
      step();
      drop_asks();
      chk("frozen mem_a", m.mem_a, 32'h301);
    end
    m.rdy = 1'b1;
    idle(6);
    chk("stalled load literal", m.ls_rdata, 32'h744F_2A05);
    idle(6);

    chk("write queue drained", 32'(wq_a.size()), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
